daq_arbiter: RTL and testbench
==============================

# daq_arbiter

Round-robin arbiter sharing one DAQ output stream among `NREQ` data-acquisition sources, such as `signal` capture channels, that use the req/grant/valid/end packet protocol. It sits between the capture blocks and the single DAQ packet FIFO/transport. It grants one source at a time, but only when downstream space can hold a worst-case packet. It forwards that source's words registered, and force-terminates a packet whose source never signals end.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `MAX_PKT_WORDS`, 102: worst-case packet length in words (2 header words + 100 data words). Grant requires `out_space >= MAX_PKT_WORDS`.
- `WD_CYCLES`, 4096: watchdog limit, in cycles, from grant to source `end`.
- `SPACE_BITS`, 10: width of `out_space`.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_req` in NREQ: per-source request level.
- `src_grant` out NREQ: one-hot grant, one-cycle pulse.
- `src_data` in 32*NREQ: source data; source k occupies bits [32k+31:32k].
- `src_valid` in NREQ: per-source data valid.
- `src_end` in NREQ: per-source end-of-packet strobe (not accompanied by data).
- `out_data` out 32: forwarded word.
- `out_valid` out 1: `out_data` valid.
- `out_end` out 1: end-of-packet strobe.
- `out_abort` out 1: qualifies `out_end`; set when the watchdog forced the end.
- `out_space` in SPACE_BITS: free words downstream.
- `busy` out 1: a packet is in flight.
- `proto_err` out 1: sticky; set when a non-granted source asserts valid or end.
- `pkt_count` out 16: completed-packet counter (see Configuration).
- `abort_count` out 8: aborted-packet counter (see Configuration).

## Operation
- State machine: IDLE, GRANT, BUSY, GAP.
- IDLE:
  - Condition: `|src_req` and `out_space >= MAX_PKT_WORDS`.
  - Winner: the first requester strictly after `last` in circular order. `last` resets to NREQ-1, so source 0 wins first.
  - Action: register winner into `sel`, set `last` to winner, pulse `src_grant[sel]`, go to GRANT.
- GRANT: lasts one cycle; the watchdog is loaded with `WD_CYCLES`; go to BUSY. Source valid is already forwarded in this cycle.
- BUSY (and GRANT):
  - Forwarding: `out_data <= src_data[sel]`, `out_valid <= src_valid[sel]`.
  - Watchdog decrements each cycle.
  - `src_end[sel]`: `out_end <= 1`, `out_abort <= 0`, increment `pkt_count`, go to GAP.
  - Watchdog reaching 0 with no end: `out_end <= 1`, `out_abort <= 1`, increment `abort_count`, go to GAP. Later words from that source are dropped and set `proto_err`.
  - `src_valid` and `src_end` on `sel` in the same cycle: the word is forwarded with `out_end` in the same output cycle.
- GAP: one idle cycle; no grant is issued; go to IDLE. This guarantees `out_end` is never followed directly by the next header.
- Valid or end from any non-selected source, at any time, sets `proto_err` (cleared only by reset). The data is discarded.
- A requester dropping `src_req` before grant is simply not granted. `src_req` is ignored after grant.
- `busy` = state is not IDLE.
- Counters wrap modulo 2^16 and 2^8 respectively.

## Timing
- Reset (async assert, sync deassert usage): state IDLE, `src_grant` 0, `out_data` 0, `out_valid` 0, `out_end` 0, `out_abort` 0, `busy` 0, `proto_err` 0, counters 0, `last` = NREQ-1, watchdog 0.
- Reset mid-packet aborts silently: no `out_end` is emitted.
- Request-to-grant latency is 1 cycle: `src_req` sampled in cycle t with space available gives `src_grant` high in t+1.
- Data latency is 1 cycle: `src_valid` in cycle t gives `out_valid` in t+1.
- End latency is 1 cycle, and the next grant is possible no earlier than 2 cycles after `out_end`.
- `out_space` is sampled only in IDLE; a drop during BUSY is not re-checked.
- Two requesters asserting in the same cycle: the one closest after `last` wins; the other wins the next arbitration if it is still requesting.

## Configuration
- `DAQ_ARB_STATS_EN`:
  - Defined: `pkt_count` and `abort_count` are implemented as described.
  - Undefined: both ports are tied to constant 0 and no counter flops exist.
  - All other behaviour is identical either way.

## Test plan
- Single source 1, `out_space`=200: req → grant pulse on bit 1 next cycle; 102 valid words forwarded 1 cycle late, unchanged; `out_end` follows; `pkt_count`=1.
- Sources 0, 2, 3 requesting continuously: grant order is 0, 2, 3, 0, 2, 3, with exactly one GAP cycle between each `out_end` and the next grant.
- `out_space`=101 with a request pending: no grant. Raise to 102 → grant next cycle.
- Granted source never asserts end, `WD_CYCLES`=16: `out_end`=1 with `out_abort`=1 at 17 cycles after grant; `abort_count`=1; later source words are dropped and `proto_err`=1.
- Source 3 asserts valid while source 0 is granted: `proto_err` becomes 1 and `out_data` shows only source 0 words.
- Assert `rst_n`=0 mid-BUSY: all outputs go to 0 immediately. After release, the next arbitration grants source 0 first.

Source files
------------

// File: rtl/daq_arbiter_if.sv
// Handshake bundle between the DAQ capture sources, the arbiter and the downstream packet FIFO.
// Latency: none (wires only).
// Backpressure: carried by out_space; sources are throttled through the req/grant exchange.
// Modports: master = source/transport side (drives requests, data and free space),
//           slave  = arbiter side (drives grants, forwarded stream, status and counters).
interface daq_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int SPACE_BITS = 10
);
    logic [NREQ-1:0]       src_req;
    logic [NREQ-1:0]       src_grant;
    logic [32*NREQ-1:0]    src_data;
    logic [NREQ-1:0]       src_valid;
    logic [NREQ-1:0]       src_end;
    logic [31:0]           out_data;
    logic                  out_valid;
    logic                  out_end;
    logic                  out_abort;
    logic [SPACE_BITS-1:0] out_space;
    logic                  busy;
    logic                  proto_err;
    logic [15:0]           pkt_count;
    logic [7:0]            abort_count;

    modport master (
        output src_req, src_data, src_valid, src_end, out_space,
        input  src_grant, out_data, out_valid, out_end, out_abort,
               busy, proto_err, pkt_count, abort_count
    );

    modport slave (
        input  src_req, src_data, src_valid, src_end, out_space,
        output src_grant, out_data, out_valid, out_end, out_abort,
               busy, proto_err, pkt_count, abort_count
    );
endinterface

// File: rtl/daq_arbiter.sv
// Round-robin arbiter sharing one DAQ output stream among NREQ capture sources.
// Latency: 1 cycle req->grant, 1 cycle src word->out word, 1 cycle src_end->out_end.
// Backpressure: grants only when out_space can absorb a worst-case packet (checked in IDLE only).
// Ports: clk, rst_n (async active-low), bus (daq_arbiter_if.slave: source req/grant/data/valid/end,
//        forwarded out_data/out_valid/out_end/out_abort, out_space, busy, proto_err, counters).
// Optional: define DAQ_ARB_STATS_EN to implement pkt_count/abort_count; otherwise both read 0.
module daq_arbiter #(
    parameter int NREQ          = 4,
    parameter int MAX_PKT_WORDS = 102,
    parameter int WD_CYCLES     = 4096,
    parameter int SPACE_BITS    = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    daq_arbiter_if.slave    bus
);
    localparam int          IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          WD_W  = $clog2(WD_CYCLES + 1);
    localparam logic [31:0] MAX_W = 32'(MAX_PKT_WORDS);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, GAP} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  sel, last, winner;
    logic              win_found;
    logic [WD_W-1:0]   wd;
    logic              space_ok, active, sel_valid, sel_end, wd_expire, stray;
    logic              take, done_ok, done_abort;
    logic [31:0]       sel_data;
    logic [NREQ-1:0]   sel_mask;

    logic [NREQ-1:0]   grant_q;
    logic [31:0]       out_data_q;
    logic              out_valid_q, out_end_q, out_abort_q, proto_err_q;

    assign space_ok  = 32'(bus.out_space) >= MAX_W;
    assign active    = (state == GRANT) || (state == BUSY);
    assign sel_data  = bus.src_data[32*int'(sel) +: 32];
    assign sel_valid = bus.src_valid[sel];
    assign sel_end   = bus.src_end[sel];
    // The watchdog is loaded during GRANT, so it can only run out while in BUSY.
    assign wd_expire = (state == BUSY) && (wd == WD_W'(1));
    // Anything from a source other than the one currently forwarded is a protocol error;
    // outside GRANT/BUSY no source is selected at all.
    assign sel_mask  = active ? (NREQ'(1) << sel) : '0;
    assign stray     = |((bus.src_valid | bus.src_end) & ~sel_mask);

    // First requester strictly after 'last' in circular order.
    always_comb begin
        winner    = last;
        win_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!win_found && bus.src_req[(int'(last) + i) % NREQ]) begin
                winner    = IDX_W'((int'(last) + i) % NREQ);
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take       = 1'b0;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && space_ok) begin
                    state_nxt = GRANT;
                    take      = 1'b1;
                end
            end
            GRANT, BUSY: begin
                // A genuine end wins over a simultaneous watchdog expiry.
                if (sel_end) begin
                    state_nxt = GAP;
                    done_ok   = 1'b1;
                end else if (wd_expire) begin
                    state_nxt  = GAP;
                    done_abort = 1'b1;
                end else begin
                    state_nxt = BUSY;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= '0;
            last        <= IDX_W'(NREQ - 1);
            wd          <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_end_q   <= 1'b0;
            out_abort_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_end_q   <= done_ok | done_abort;
            out_abort_q <= done_abort;
            if (take) begin
                sel     <= winner;
                last    <= winner;
                grant_q <= NREQ'(1) << winner;
            end
            if (active) begin
                out_data_q  <= sel_data;
                out_valid_q <= sel_valid;
            end
            if (state == GRANT)
                wd <= WD_W'(WD_CYCLES);
            else if (state == BUSY && wd != '0)
                wd <= wd - WD_W'(1);
            if (stray)
                proto_err_q <= 1'b1;
        end
    end

`ifdef DAQ_ARB_STATS_EN
    logic [15:0] pkt_cnt;
    logic [7:0]  abort_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt   <= '0;
            abort_cnt <= '0;
        end else begin
            if (done_ok)    pkt_cnt   <= pkt_cnt + 16'd1;
            if (done_abort) abort_cnt <= abort_cnt + 8'd1;
        end
    end

    assign bus.pkt_count   = pkt_cnt;
    assign bus.abort_count = abort_cnt;
`else
    assign bus.pkt_count   = '0;
    assign bus.abort_count = '0;
`endif

    assign bus.src_grant = grant_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_end   = out_end_q;
    assign bus.out_abort = out_abort_q;
    assign bus.busy      = (state != IDLE);
    assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_daq_arbiter.sv
// Directed bench for daq_arbiter: arbitration vector table plus hand-written packet sequences.
// A second instance with a short watchdog covers the forced-termination path.
module tb_daq_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    daq_arbiter_if #(.NREQ(4), .SPACE_BITS(10)) bus  ();
    daq_arbiter_if #(.NREQ(4), .SPACE_BITS(10)) wbus ();

    daq_arbiter #(.NREQ(4), .MAX_PKT_WORDS(102), .WD_CYCLES(4096), .SPACE_BITS(10)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));

    daq_arbiter #(.NREQ(4), .MAX_PKT_WORDS(102), .WD_CYCLES(16), .SPACE_BITS(10)) dut_wd (
        .clk(clk), .rst_n(rst_n), .bus(wbus.slave));

`ifdef DAQ_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [3:0] req;
        logic [9:0] space;
        logic [3:0] gnt;
    } vec_t;

    vec_t vt [12];
    int   total    = 0;
    int   bad      = 0;
    int   exp_pkts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic v, input logic e, input logic [31:0] d);
        bus.src_valid = '0;
        bus.src_end   = '0;
        bus.src_valid[s] = v;
        bus.src_end[s]   = e;
        bus.src_data[32*s +: 32] = d;
    endtask

    task automatic clear_src;
        bus.src_valid = '0;
        bus.src_end   = '0;
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          s;
        logic        early;

        // {req, space, expected grant}; 'last' carries over from row to row.
        vt[0]  = '{4'b0000, 10'd200,  4'b0000};
        vt[1]  = '{4'b1111, 10'd101,  4'b0000};
        vt[2]  = '{4'b1111, 10'd102,  4'b0001};
        vt[3]  = '{4'b1101, 10'd200,  4'b0100};
        vt[4]  = '{4'b1101, 10'd200,  4'b1000};
        vt[5]  = '{4'b1101, 10'd200,  4'b0001};
        vt[6]  = '{4'b1101, 10'd200,  4'b0100};
        vt[7]  = '{4'b1101, 10'd200,  4'b1000};
        vt[8]  = '{4'b0010, 10'd1023, 4'b0010};
        vt[9]  = '{4'b0011, 10'd200,  4'b0001};
        vt[10] = '{4'b0110, 10'd0,    4'b0000};
        vt[11] = '{4'b0110, 10'd102,  4'b0010};

        bus.src_req = '0; bus.src_data = '0; bus.src_valid = '0; bus.src_end = '0; bus.out_space = '0;
        wbus.src_req = '0; wbus.src_data = '0; wbus.src_valid = '0; wbus.src_end = '0; wbus.out_space = '0;

        #12;
        chk("rst_grant",     32'(bus.src_grant), 32'd0);
        chk("rst_out_data",  bus.out_data,       32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_end",   32'(bus.out_end),   32'd0);
        chk("rst_out_abort", 32'(bus.out_abort), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
        chk("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
        chk("rst_abort_cnt", 32'(bus.abort_count), 32'd0);
        #2 rst_n = 1'b1;

        for (int r = 0; r < 12; r++) begin
            bus.src_req   = vt[r].req;
            bus.out_space = vt[r].space;
            tick;
            chk($sformatf("vec%0d_grant", r), 32'(bus.src_grant), 32'(vt[r].gnt));
            if (vt[r].gnt != 4'b0000) begin
                s = 0;
                for (int k = 0; k < 4; k++) if (vt[r].gnt[k]) s = k;
                d = {8'hA0, 8'(r), 16'h0000};
                drive(s, 1'b1, 1'b0, d);
                tick;
                chk($sformatf("vec%0d_w0_valid", r), 32'(bus.out_valid), 32'd1);
                chk($sformatf("vec%0d_w0_data", r),  bus.out_data, d);
                chk($sformatf("vec%0d_w0_end", r),   32'(bus.out_end), 32'd0);
                drive(s, 1'b1, 1'b1, d + 32'd1);
                tick;
                exp_pkts++;
                chk($sformatf("vec%0d_w1_data", r),  bus.out_data, d + 32'd1);
                chk($sformatf("vec%0d_end", r),      {bus.out_valid, bus.out_end, bus.out_abort}, 32'b110);
                chk($sformatf("vec%0d_gap_grant", r), 32'(bus.src_grant), 32'd0);
                chk($sformatf("vec%0d_gap_busy", r), 32'(bus.busy), 32'd1);
                clear_src;
                tick;
                chk($sformatf("vec%0d_idle_busy", r), 32'(bus.busy), 32'd0);
                chk($sformatf("vec%0d_idle_grant", r), 32'(bus.src_grant), 32'd0);
            end
        end
        chk("table_proto_err", 32'(bus.proto_err), 32'd0);
        chk("table_pkt_count", 32'(bus.pkt_count), exp_cnt(exp_pkts));

        // Full worst-case packet from source 1.
        bus.src_req = 4'b0010; bus.out_space = 10'd200;
        tick;
        chk("long_grant", 32'(bus.src_grant), 32'b0010);
        bus.src_req = '0;
        for (int i = 0; i < 102; i++) begin
            drive(1, 1'b1, 1'b0, 32'hB000_0000 + 32'(i));
            tick;
            chk($sformatf("long_word%0d", i), bus.out_valid ? bus.out_data : 32'hDEAD_BEEF,
                32'hB000_0000 + 32'(i));
        end
        drive(1, 1'b0, 1'b1, 32'd0);
        tick;
        exp_pkts++;
        chk("long_end", {bus.out_valid, bus.out_end, bus.out_abort}, 32'b010);
        clear_src;
        chk("long_pkt_count", 32'(bus.pkt_count), exp_cnt(exp_pkts));
        tick;

        // Stray valid from source 3 while source 0 owns the stream.
        bus.src_req = 4'b0001;
        tick;
        chk("stray_grant", 32'(bus.src_grant), 32'b0001);
        bus.src_req = '0;
        drive(0, 1'b1, 1'b0, 32'hC0C0_0000);
        bus.src_valid[3] = 1'b1;
        bus.src_data[127:96] = 32'h3333_3333;
        tick;
        chk("stray_data", bus.out_data, 32'hC0C0_0000);
        chk("stray_proto_err", 32'(bus.proto_err), 32'd1);
        drive(0, 1'b0, 1'b1, 32'd0);
        tick;
        exp_pkts++;
        chk("stray_end", 32'(bus.out_end), 32'd1);
        clear_src;
        tick;

        // Reset in the middle of a packet.
        bus.src_req = 4'b0100;
        tick;
        chk("mid_rst_grant", 32'(bus.src_grant), 32'b0100);
        bus.src_req = '0;
        drive(2, 1'b1, 1'b0, 32'hD00D_0001);
        tick;
        chk("mid_rst_pre_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_data",  bus.out_data, 32'd0);
        chk("mid_rst_busy",      32'(bus.busy), 32'd0);
        chk("mid_rst_proto_err", 32'(bus.proto_err), 32'd0);
        chk("mid_rst_pkt_count", 32'(bus.pkt_count), 32'd0);
        clear_src;
        exp_pkts = 0;
        tick;
        chk("mid_rst_no_end", 32'(bus.out_end), 32'd0);
        #3 rst_n = 1'b1;
        bus.src_req = 4'b1111;
        tick;
        chk("post_rst_grant", 32'(bus.src_grant), 32'b0001);
        bus.src_req = '0;
        drive(0, 1'b0, 1'b1, 32'd0);
        tick;
        exp_pkts++;
        chk("post_rst_end", 32'(bus.out_end), 32'd1);
        clear_src;
        chk("post_rst_pkt_count", 32'(bus.pkt_count), exp_cnt(exp_pkts));
        tick;

        // Watchdog: source 2 streams words but never ends, limit 16 cycles.
        wbus.out_space = 10'd200;
        wbus.src_req   = 4'b0100;
        tick;
        chk("wd_grant", 32'(wbus.src_grant), 32'b0100);
        wbus.src_req = '0;
        early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            wbus.src_valid[2] = 1'b1;
            wbus.src_data[95:64] = 32'hE000_0000 + 32'(k);
            tick;
            if (wbus.out_end) early = 1'b1;
        end
        chk("wd_no_early_end", 32'(early), 32'd0);
        chk("wd_no_early_err", 32'(wbus.proto_err), 32'd0);
        tick;
        chk("wd_abort_end", {wbus.out_end, wbus.out_abort}, 32'b11);
        chk("wd_abort_count", 32'(wbus.abort_count), exp_cnt(1));
        chk("wd_pkt_count", 32'(wbus.pkt_count), 32'd0);
        tick;
        chk("wd_late_proto_err", 32'(wbus.proto_err), 32'd1);
        chk("wd_late_dropped", 32'(wbus.out_valid), 32'd0);
        chk("wd_late_busy", 32'(wbus.busy), 32'd0);
        wbus.src_valid = '0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
